// File: rtl/cen_pll_pkg.sv
// cen_pll_pkg: shared lock-state type, default sizes and rate helper for cen_pll
package cen_pll_pkg;
  typedef enum logic {WAIT, LOCKED} lock_state_t;
  localparam int ACC_W_DEF = 24;
  localparam int LOCK_CYCLES_DEF = 1024;
  // Increment giving f_out strobes per second from f_ref, rounded to nearest.
  function automatic longint inc_for(real f_ref_hz, real f_out_hz, int acc_w);
    return longint'($rtoi(f_out_hz * (2.0 ** acc_w) / f_ref_hz + 0.5));
  endfunction
endpackage

// File: rtl/cen_pll_ch.sv
// cen_pll_ch: one channel's phase accumulator producing a carry strobe and a toggle output
module cen_pll_ch #(
  parameter int ACC_W = 24
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [ACC_W-1:0] load_inc,
  input  logic [ACC_W-1:0] load_phase,
  output logic             cen,
  output logic             clkout
);
  logic [ACC_W-1:0] acc, inc;
  logic [ACC_W:0] sum;
  assign sum = {1'b0, acc} + {1'b0, inc};
  // Accumulate every cycle; a load replaces rate and phase and suppresses this cycle's carry.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      inc    <= '0;
      cen    <= 1'b0;
      clkout <= 1'b0;
    end else if (load) begin
      acc    <= load_phase;
      inc    <= load_inc;
      cen    <= 1'b0;
      clkout <= 1'b0;
    end else begin
      acc    <= sum[ACC_W-1:0];
      cen    <= sum[ACC_W];
      clkout <= clkout ^ sum[ACC_W];
    end
  end
endmodule

// File: rtl/cen_pll.sv
// cen_pll: multi-channel fractional clock-enable synthesiser with config port and lock indicator
module cen_pll
  import cen_pll_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ACC_W = ACC_W_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] cen,
  output logic [NUM_CH-1:0] clkout,
  output logic              locked
);
  localparam int CNT_W = $clog2(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LOCK_CYCLES - 1);
  lock_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic cfg_hit;
  assign cfg_hit = cfg_valid && cfg_ready && (32'(cfg_ch) < NUM_CH);
  assign locked = (state == LOCKED);
  genvar i;
  for (i = 0; i < NUM_CH; i++) begin : g_ch
    cen_pll_ch #(.ACC_W(ACC_W)) u_ch (
      .refclk    (refclk),
      .rst_n     (rst_n),
      .load      (cfg_hit && cfg_ch == CH_W'(i)),
      .load_inc  (cfg_inc),
      .load_phase(cfg_phase),
      .cen       (cen[i]),
      .clkout    (clkout[i])
    );
  end
  // Lock state, counter and the always-ready config handshake.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT;
      cnt       <= '0;
      cfg_ready <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cfg_ready <= 1'b1;
    end
  end
  // Any valid reconfiguration restarts the settling count; otherwise count up to lock.
  always_comb begin
    state_nxt = cfg_hit ? WAIT : (state == WAIT && cnt == LAST) ? LOCKED : state;
    cnt_nxt   = cfg_hit ? '0 : (state == WAIT) ? cnt + 1'b1 : cnt;
  end
endmodule

// File: tb/tb_cen_pll.sv
// tb_cen_pll: randomized scoreboard bench for cen_pll against a wrap-count reference model
module tb_cen_pll;
  import cen_pll_pkg::*;
  localparam int NCH = 3;
  localparam int W = 8;
  localparam int LC = 1024;
  localparam int CHW = 2;
  localparam longint M = 256;
  typedef struct packed {
    logic [NCH-1:0] cen;
    logic [NCH-1:0] clk;
    logic           locked;
    logic           ready;
  } exp_t;
  logic refclk = 0, rst_n = 0, cfg_valid = 0, cfg_ready, locked;
  logic [CHW-1:0] cfg_ch = '0;
  logic [W-1:0] cfg_inc = '0, cfg_phase = '0;
  logic [NCH-1:0] cen, clkout;
  exp_t q[$];
  exp_t last, me;
  int checks = 0, passed = 0;
  longint m_ph[NCH], m_inc[NCH], m_k[NCH];
  int m_n = 0;
  bit m_ready = 0;

  cen_pll #(.NUM_CH(NCH), .ACC_W(W), .LOCK_CYCLES(LC)) dut (
    .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_phase(cfg_phase),
    .cen(cen), .clkout(clkout), .locked(locked)
  );

  always #5 refclk = ~refclk;

  // Number of accumulator wraps k cycles after the channel was loaded.
  function automatic longint wraps(int c, longint k);
    return (m_ph[c] + k * m_inc[c]) / M;
  endfunction

  task automatic check(string name, longint act, longint req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Drive one cycle, advance the reference model across the edge and queue the expectation.
  task automatic step(bit v, int ch, int inc, int ph);
    bit hit;
    exp_t e;
    cfg_valid = v; cfg_ch = CHW'(ch); cfg_inc = W'(inc); cfg_phase = W'(ph);
    @(posedge refclk);
    if (!rst_n) begin
      m_ready = 0; m_n = 0;
      for (int c = 0; c < NCH; c++) begin m_ph[c] = 0; m_inc[c] = 0; m_k[c] = 0; end
    end else begin
      hit = v && m_ready && ch < NCH;
      for (int c = 0; c < NCH; c++)
        if (hit && c == ch) begin m_ph[c] = ph; m_inc[c] = inc; m_k[c] = 0; end
        else m_k[c]++;
      m_n = hit ? 0 : m_n + 1;
      m_ready = 1;
    end
    for (int c = 0; c < NCH; c++) begin
      e.cen[c] = m_k[c] > 0 && wraps(c, m_k[c]) != wraps(c, m_k[c] - 1);
      e.clk[c] = (wraps(c, m_k[c]) % 2) == 1;
    end
    e.locked = m_n >= LC;
    e.ready = m_ready;
    q.push_back(e);
    last = e;
    #1 cfg_valid = 0;
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  // Monitor: compare each queued expectation half a cycle after its edge.
  always @(negedge refclk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      check("cen_clkout", {cen, clkout}, {me.cen, me.clk});
      check("locked_ready", {locked, cfg_ready}, {me.locked, me.ready});
    end
  end

  initial begin
    int ri, rp, n_cen, n_bad, tries;
    logic prev;
    check("inc_for_18M", inc_for(50.0e6, 18.0e6, 24), 6039798);
    check("inc_for_12M", inc_for(50.0e6, 12.0e6, 24), 4026532);
    idle(3);
    #5 rst_n = 1;
    idle(1030);
    step(1, 0, 128, 128);
    step(1, 1, $urandom_range(1, 255), $urandom_range(0, 255));
    step(1, 2, $urandom_range(1, 255), $urandom_range(0, 255));
    idle(40);
    ri = $urandom_range(1, 255);
    rp = $urandom_range(0, 255);
    step(1, 0, ri, rp);
    prev = clkout[0]; n_cen = 0; n_bad = 0;
    repeat (256) begin
      step(0, 0, 0, 0);
      n_cen += int'(cen[0]);
      if (clkout[0] != prev && !cen[0]) n_bad++;
      prev = clkout[0];
    end
    check("strobe_count", n_cen, ri);
    check("clkout_no_cen", n_bad, 0);
    repeat (10) step(1, 0, $urandom_range(0, 255), $urandom_range(0, 255));
    idle(1030);
    step(1, 3, $urandom_range(1, 255), $urandom_range(0, 255));
    idle(5);
    repeat (400) step($urandom_range(0, 9) == 0, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255));
    step(1, 0, 128, 0);
    tries = 0;
    while (!(last.cen != 0 && last.clk != 0) && tries < 50) begin step(0, 0, 0, 0); tries++; end
    check("found_high_outputs", tries < 50, 1);
    #5 rst_n = 0;
    #1 check("async_reset", {cen, clkout, locked, cfg_ready}, 0);
    idle(3);
    #5 rst_n = 1;
    idle(1030);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge refclk);
    check("drain", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
